cbus_arbiter: RTL and testbench

- N-to-1 round-robin arbiter on the cbus protocol. It sits directly downstream of the MMU instances: the instruction-side MMU and the data-side MMU each drive one input port, and the single output goes to the memory/AXI bridge.
- It grants one master at a time and holds that grant for the whole transaction, including every burst beat.
- Grant is released on the final beat, and priority then rotates so neither master starves.

---
 rtl/cbus_arbiter.sv | 125 ++++++++++++
 tb/tb_cbus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: N:1 round-robin arbiter between cbus masters and the bridge.
// A grant is held for the whole burst and priority rotates after the last beat.
package cbus_pkg;

  typedef enum logic [1:0] {
    MLEN1,
    MLEN2,
    MLEN4,
    MLEN8
  } cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    cbus_len_t   len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;

endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_REQ],
  output cbus_resp_t       iresps [NUM_REQ],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx
);

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  localparam logic [IDX_W:0]   NUM_W  = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] prio_q, prio_d;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] gnt_inc;
  logic [IDX_W:0]   slot;
  logic             pick_vld;

  // Descending scan so the candidate nearest prio is written last and wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    slot     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      slot = {1'b0, prio_q} + (IDX_W+1)'(k);
      if (slot >= NUM_W) begin
        slot = slot - NUM_W;
      end
      if (ireqs[slot[IDX_W-1:0]].valid) begin
        pick_vld = 1'b1;
        pick_idx = slot[IDX_W-1:0];
      end
    end
  end

  assign gnt_inc = (gnt_q == LAST_I) ? '0 : gnt_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    oreq    = '0;
    busy    = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      iresps[j] = '0;
    end
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_idx;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        busy          = 1'b1;
        oreq          = ireqs[gnt_q];
        iresps[gnt_q] = oresp;
        if (oresp.ready && oresp.last) begin
          state_d = ARB_IDLE;
          prio_d  = gnt_inc;
        end else if (!ireqs[gnt_q].valid) begin
          // Abandoned transaction: no rotation, master keeps its turn.
          state_d = ARB_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
    end
  end

  assign grant_idx = gnt_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: scoreboard bench for cbus_arbiter.
// Directed scenarios followed by randomized masters and bridge.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N  = 2;
  localparam int IW = 1;

  typedef struct packed {
    logic                 busy;
    logic [IW-1:0]        gidx;
    cbus_req_t            oreq;
    cbus_resp_t [N-1:0]   ir;
  } exp_t;

  typedef struct {
    int          idx;
    logic [31:0] addr;
  } gnt_t;

  logic          clk = 1'b0;
  logic          reset;
  cbus_req_t     d_req  [N];
  cbus_resp_t    d_resp [N];
  cbus_req_t     oreq;
  cbus_resp_t    oresp;
  logic          busy;
  logic [IW-1:0] grant_idx;

  cbus_req_t  s_req [N];
  cbus_resp_t s_resp;
  logic       s_rst;

  exp_t exp_q[$];
  gnt_t gnt_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference: owner of the bus (-1 = none), next-first master, last grant.
  int owner = -1;
  int rr    = 0;
  int mg    = 0;
  int bcnt  = 0;
  bit done [N];

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk),
    .reset(reset),
    .ireqs(d_req),
    .iresps(d_resp),
    .oreq(oreq),
    .oresp(oresp),
    .busy(busy),
    .grant_idx(grant_idx)
  );

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic int beats(cbus_len_t l);
    return 1 << int'(l);
  endfunction

  task automatic set_req(int i, logic [31:0] a, cbus_len_t l);
    s_req[i]       = '0;
    s_req[i].valid = 1'b1;
    s_req[i].write = 1'($urandom_range(0, 1));
    s_req[i].addr  = a;
    s_req[i].wdata = $urandom;
    s_req[i].wstrb = 4'hf;
    s_req[i].len   = l;
  endtask

  task automatic set_resp(logic rdy, logic lst);
    s_resp.ready = rdy;
    s_resp.last  = lst;
    s_resp.rdata = $urandom;
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    reset = s_rst;
    d_req = s_req;
    oresp = s_resp;
    #1;
    e = '0;
    if (!s_rst) begin
      owner = -1;
      rr    = 0;
      mg    = 0;
    end else begin
      e.gidx = IW'(mg);
      if (owner >= 0) begin
        e.busy      = 1'b1;
        e.oreq      = s_req[owner];
        e.ir[owner] = s_resp;
        if (s_resp.ready && s_resp.last) begin
          done[owner] = 1'b1;
          rr          = (owner + 1) % N;
          owner       = -1;
        end else if (!s_req[owner].valid) begin
          owner = -1;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (rr + k) % N;
          if (owner < 0 && s_req[i].valid) begin
            owner = i;
            mg    = i;
            bcnt  = 0;
            gnt_q.push_back('{i, s_req[i].addr});
          end
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic agents(bit allow_new);
    for (int i = 0; i < N; i++) begin
      if (done[i]) begin
        done[i] = 1'b0;
        if (allow_new && $urandom_range(0, 1) == 1)
          set_req(i, $urandom, cbus_len_t'($urandom_range(0, 3)));
        else
          s_req[i].valid = 1'b0;
      end else if (!s_req[i].valid) begin
        if (allow_new && $urandom_range(0, 3) == 0)
          set_req(i, $urandom, cbus_len_t'($urandom_range(0, 3)));
      end else if ($urandom_range(0, 15) == 0) begin
        s_req[i].wdata = $urandom;
      end
    end
    if (owner >= 0) begin
      if ($urandom_range(0, 1) == 1) begin
        bcnt++;
        set_resp(1'b1, bcnt == beats(s_req[owner].len));
      end else begin
        set_resp(1'b0, 1'b0);
      end
    end else begin
      set_resp($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin : monitor
    exp_t e;
    gnt_t g;
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("busy", 128'(busy), 128'(e.busy));
        chk("grant_idx", 128'(grant_idx), 128'(e.gidx));
        chk("oreq", 128'(oreq), 128'(e.oreq));
        for (int i = 0; i < N; i++)
          chk($sformatf("iresps%0d", i), 128'(d_resp[i]), 128'(e.ir[i]));
        if (oreq.valid && !prev_v) begin
          if (gnt_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL grant_start got=master%0d exp=no_grant", grant_idx);
          end else begin
            g = gnt_q.pop_front();
            chk("grant_master", 128'(grant_idx), 128'(g.idx));
            chk("grant_addr", 128'(oreq.addr), 128'(g.addr));
          end
        end
        prev_v = oreq.valid;
      end
    end
  end

  initial begin : stim
    bit pat [7];
    int nb;
    pat   = '{1, 0, 1, 1, 0, 0, 1};
    s_rst = 1'b0;
    for (int i = 0; i < N; i++) s_req[i] = '0;
    s_resp = '0;
    reset  = 1'b0;
    d_req  = s_req;
    oresp  = s_resp;
    step();
    step();
    s_rst = 1'b1;
    step();

    // Single master 0, MLEN1, last on the third busy cycle.
    set_req(0, 32'h8000_0000, MLEN1);
    step();
    step();
    step();
    set_resp(1'b1, 1'b1);
    step();
    set_resp(1'b0, 1'b0);
    s_req[0].valid = 1'b0;
    step();
    step();

    // Both masters right after reset.
    s_rst = 1'b0;
    step();
    s_rst = 1'b1;
    set_req(0, $urandom, MLEN1);
    set_req(1, $urandom, MLEN1);
    step();
    set_resp(1'b1, 1'b1);
    step();
    set_resp(1'b0, 1'b0);
    s_req[0].valid = 1'b0;
    step();
    set_resp(1'b1, 1'b1);
    step();
    set_resp(1'b0, 1'b0);
    s_req[1].valid = 1'b0;
    step();

    // Master 1 burst of 4 with gaps; master 0 waits.
    set_req(1, $urandom, MLEN4);
    step();
    set_req(0, $urandom, MLEN1);
    nb = 0;
    for (int k = 0; k < 7; k++) begin
      if (pat[k]) nb++;
      set_resp(pat[k], pat[k] && nb == 4);
      step();
    end
    set_resp(1'b0, 1'b0);
    s_req[1].valid = 1'b0;
    step();
    set_resp(1'b1, 1'b1);
    step();
    set_resp(1'b0, 1'b0);
    s_req[0].valid = 1'b0;
    step();

    // Both continuously valid: grants alternate.
    s_rst = 1'b0;
    step();
    s_rst = 1'b1;
    repeat (4) begin
      set_req(0, $urandom, MLEN1);
      set_req(1, $urandom, MLEN1);
      set_resp(1'b0, 1'b0);
      step();
      set_resp(1'b1, 1'b1);
      step();
    end
    set_resp(1'b0, 1'b0);
    s_req[0].valid = 1'b0;
    s_req[1].valid = 1'b0;
    step();

    // Master 0 abandons, stray beat while idle, prio stays at 0.
    s_rst = 1'b0;
    step();
    s_rst = 1'b1;
    set_req(0, $urandom, MLEN2);
    step();
    step();
    step();
    s_req[0].valid = 1'b0;
    step();
    set_resp(1'b1, 1'b1);
    step();
    set_resp(1'b0, 1'b0);
    set_req(0, $urandom, MLEN1);
    set_req(1, $urandom, MLEN1);
    step();
    set_resp(1'b1, 1'b1);
    step();
    set_resp(1'b0, 1'b0);
    s_req[0].valid = 1'b0;
    step();
    set_resp(1'b1, 1'b1);
    step();
    set_resp(1'b0, 1'b0);
    s_req[1].valid = 1'b0;
    step();

    // Reset in the middle of a burst.
    set_req(1, $urandom, MLEN4);
    step();
    set_resp(1'b1, 1'b0);
    step();
    s_rst = 1'b0;
    step();
    step();
    s_rst = 1'b1;
    set_resp(1'b0, 1'b0);
    set_req(0, $urandom, MLEN1);
    step();
    set_resp(1'b1, 1'b1);
    step();
    set_resp(1'b0, 1'b0);
    s_req[0].valid = 1'b0;
    s_req[1].valid = 1'b0;
    step();

    // Randomized traffic, then drain.
    for (int i = 0; i < N; i++) done[i] = 1'b0;
    repeat (3000) begin
      agents(1'b1);
      step();
    end
    repeat (300) begin
      agents(1'b0);
      step();
    end
    @(negedge clk);
    #3;
    chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
    chk("grant_q_drained", 128'(gnt_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
